// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and lane map for the elastic stage registers between pipeline stages.
// Lane indices describe the decode->execute bundle layout (lane 0 in the LSBs).
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    localparam int unsigned LANE_PIX1     = 0;
    localparam int unsigned LANE_PIX2     = 1;
    localparam int unsigned LANE_PIX3     = 2;
    localparam int unsigned LANE_PIX4     = 3;
    localparam int unsigned LANE_PIX5     = 4;
    localparam int unsigned LANE_PIX6     = 5;
    localparam int unsigned LANE_CTE1     = 6;
    localparam int unsigned LANE_CTE2     = 7;
    localparam int unsigned LANE_CTE3     = 8;
    localparam int unsigned LANE_CTE4     = 9;
    localparam int unsigned LANE_CTE5     = 10;
    localparam int unsigned LANE_MUL1     = 11;
    localparam int unsigned LANE_MUL2     = 12;
    localparam int unsigned LANE_MUL3     = 13;
    localparam int unsigned LANE_MUL4     = 14;
    localparam int unsigned LANE_MUL5     = 15;
    localparam int unsigned LANE_I        = 16;
    localparam int unsigned LANE_J        = 17;
    localparam int unsigned LANE_N        = 18;
    localparam int unsigned LANE_WOM_ADDR = 19;
    localparam int unsigned DEX_LANES     = 20;

endpackage

// File: rtl/pipe_stage_reg_flopenr.sv
// Enable-gated register with asynchronous active-low reset to zero.
module flopenr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: valid/ready handshake, main + skid entry, flush squashes ctrl.
// in_ready depends only on registered state and flush, never on out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_LANES = 20,
    parameter int unsigned CTRL_W    = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic [1:0]                  occ
);

    localparam int unsigned BUS_W = NUM_LANES * DATA_W;

    stage_state_t r_state;
    stage_state_t w_state_nxt;

    logic              w_in_acc;
    logic              w_out_acc;
    logic              w_ld_main_in;
    logic              w_ld_main_skid;
    logic              w_ld_skid;
    logic              w_main_en;
    logic              w_main_ctrl_en;
    logic              w_skid_ctrl_en;
    logic [BUS_W-1:0]  w_main_data_d;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [CTRL_W-1:0] w_skid_ctrl_d;
    logic [BUS_W-1:0]  r_main_data;
    logic [BUS_W-1:0]  r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [CTRL_W-1:0] r_skid_ctrl;

    assign in_ready  = (r_state != ST_FULL) & ~flush;
    assign out_valid = (r_state != ST_EMPTY);
    assign occ       = r_state;
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;

    assign w_in_acc  = in_valid & in_ready;
    assign w_out_acc = out_valid & out_ready;

    // in_acc already excludes flush; the skid->main move must be blocked explicitly.
    assign w_ld_main_in   = w_in_acc & ((r_state == ST_EMPTY) | ((r_state == ST_ONE) & w_out_acc));
    assign w_ld_main_skid = (r_state == ST_FULL) & w_out_acc & ~flush;
    assign w_ld_skid      = (r_state == ST_ONE) & w_in_acc & ~w_out_acc;

    assign w_main_en     = w_ld_main_in | w_ld_main_skid;
    assign w_main_data_d = w_ld_main_skid ? r_skid_data : in_data;

    // Synchronous ctrl clear is folded into the enable/data path of the ctrl flops.
    assign w_main_ctrl_en = w_main_en | flush;
    assign w_main_ctrl_d  = flush ? '0 : (w_ld_main_skid ? r_skid_ctrl : in_ctrl);
    assign w_skid_ctrl_en = w_ld_skid | flush;
    assign w_skid_ctrl_d  = flush ? '0 : in_ctrl;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_acc) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_in_acc && !w_out_acc)      w_state_nxt = ST_FULL;
                    else if (!w_in_acc && w_out_acc) w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_out_acc) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    flopenr #(.WIDTH(BUS_W)) u_main_data (
        .clk (clk), .rst (rst), .en (w_main_en), .d (w_main_data_d), .q (r_main_data)
    );

    flopenr #(.WIDTH(BUS_W)) u_skid_data (
        .clk (clk), .rst (rst), .en (w_ld_skid), .d (in_data), .q (r_skid_data)
    );

    flopenr #(.WIDTH(CTRL_W)) u_main_ctrl (
        .clk (clk), .rst (rst), .en (w_main_ctrl_en), .d (w_main_ctrl_d), .q (r_main_ctrl)
    );

    flopenr #(.WIDTH(CTRL_W)) u_skid_ctrl (
        .clk (clk), .rst (rst), .en (w_skid_ctrl_en), .d (w_skid_ctrl_d), .q (r_skid_ctrl)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: default-width stage and an 8-bit/1-lane/1-bit-ctrl stage driven in lockstep.
module tb_pipe_stage_reg;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [5:0]   in_ctrl;
    logic [639:0] in_data;
    logic         flush;
    logic         out_ready;

    logic         a_in_ready, a_out_valid;
    logic [5:0]   a_out_ctrl;
    logic [639:0] a_out_data;
    logic [1:0]   a_occ;

    logic         b_in_ready, b_out_valid;
    logic [0:0]   b_out_ctrl;
    logic [7:0]   b_out_data;
    logic [1:0]   b_occ;
    logic [0:0]   b_in_ctrl;
    logic [7:0]   b_in_data;

    int unsigned  n_checks;
    int unsigned  n_errors;
    int unsigned  n_cons;
    int unsigned  cons_before;

    assign b_in_ctrl = in_ctrl[0];
    assign b_in_data = in_data[7:0];

    pipe_stage_reg u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_ctrl  (a_out_ctrl),
        .out_data  (a_out_data),
        .occ       (a_occ)
    );

    pipe_stage_reg #(.DATA_W(8), .NUM_LANES(1), .CTRL_W(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_ctrl   (b_in_ctrl),
        .in_data   (b_in_data),
        .flush     (flush),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_ctrl  (b_out_ctrl),
        .out_data  (b_out_data),
        .occ       (b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes seen mid-cycle complete on the following rising edge.
    always @(negedge clk) begin
        if (a_out_valid && out_ready) n_cons++;
    end

    task automatic check_val(input string tag, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_valid, input logic [1:0] exp_occ,
                             input logic [5:0] exp_ctrl, input logic [639:0] exp_data);
        logic [7:0] exp_b;
        exp_b = exp_data[7:0];
        check_val({tag, ".a_valid"}, {639'd0, a_out_valid}, {639'd0, exp_valid});
        check_val({tag, ".a_occ"},   {638'd0, a_occ},       {638'd0, exp_occ});
        check_val({tag, ".a_ctrl"},  {634'd0, a_out_ctrl},  {634'd0, exp_ctrl});
        check_val({tag, ".a_data"},  a_out_data,            exp_data);
        check_val({tag, ".b_valid"}, {639'd0, b_out_valid}, {639'd0, exp_valid});
        check_val({tag, ".b_occ"},   {638'd0, b_occ},       {638'd0, exp_occ});
        check_val({tag, ".b_ctrl"},  {639'd0, b_out_ctrl},  {639'd0, exp_ctrl[0]});
        check_val({tag, ".b_data"},  {632'd0, b_out_data},  {632'd0, exp_b});
    endtask

    task automatic check_rdy(input string tag, input logic exp);
        check_val({tag, ".a_rdy"}, {639'd0, a_in_ready}, {639'd0, exp});
        check_val({tag, ".b_rdy"}, {639'd0, b_in_ready}, {639'd0, exp});
    endtask

    function automatic logic [639:0] bundle(input int unsigned c);
        logic [639:0] b;
        for (int unsigned k = 0; k < 20; k++) begin
            b[k*32 +: 32] = ((k + 1) << 16) | (c + 1);
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] c, input logic [639:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_cons    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #1 rst = 1'b0;
        #2;
        check_out("reset", 1'b0, 2'd0, 6'h00, '0);
        check_rdy("reset", 1'b1);
        tick();
        drive(1'b1, 6'h21, bundle(0));
        tick();
        check_out("reset_hold", 1'b0, 2'd0, 6'h00, '0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 6'h00, '0);
        tick();
        check_out("post_reset", 1'b0, 2'd0, 6'h00, '0);

        // Streaming: one bundle per cycle, 1-cycle latency, no bubbles
        out_ready = 1'b1;
        n_cons    = 0;
        for (int unsigned c = 0; c < 10; c++) begin
            drive(1'b1, 6'h21, bundle(c));
            #1 check_rdy($sformatf("stream_rdy%0d", c), 1'b1);
            tick();
            check_out($sformatf("stream%0d", c), 1'b1, 2'd1, 6'h21, bundle(c));
        end
        drive(1'b0, 6'h00, '0);
        tick();
        check_out("stream_drain", 1'b0, 2'd0, 6'h00, bundle(9));
        check_val("stream_count", {608'd0, n_cons}, {608'd0, 32'd10});

        // Backpressure: skid absorbs one bundle, then in_ready drops
        drive(1'b1, 6'h21, bundle(0));
        tick();
        check_out("bp_first", 1'b1, 2'd1, 6'h21, bundle(0));
        out_ready = 1'b0;
        drive(1'b1, 6'h21, bundle(1));
        #1 check_rdy("bp_rdy_one", 1'b1);
        tick();
        check_out("bp_full", 1'b1, 2'd2, 6'h21, bundle(0));
        drive(1'b1, 6'h21, bundle(2));
        #1 check_rdy("bp_rdy_full", 1'b0);
        tick();
        check_out("bp_stall", 1'b1, 2'd2, 6'h21, bundle(0));
        out_ready = 1'b1;
        #1 check_rdy("bp_rdy_release", 1'b0);
        tick();
        check_out("bp_out2", 1'b1, 2'd1, 6'h21, bundle(1));
        tick();
        check_out("bp_out3", 1'b1, 2'd1, 6'h21, bundle(2));
        drive(1'b1, 6'h21, bundle(3));
        tick();
        check_out("bp_out4", 1'b1, 2'd1, 6'h21, bundle(3));
        drive(1'b0, 6'h00, '0);
        tick();
        check_out("bp_empty", 1'b0, 2'd0, 6'h00, bundle(3));

        // Flush while full: squash, drop the presented input, data regs hold
        out_ready = 1'b0;
        drive(1'b1, 6'h3F, bundle(4));
        tick();
        drive(1'b1, 6'h3F, bundle(5));
        tick();
        check_out("fl_full", 1'b1, 2'd2, 6'h3F, bundle(4));
        drive(1'b1, 6'h3F, bundle(6));
        flush = 1'b1;
        #1 check_rdy("fl_rdy", 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, 6'h00, '0);
        check_out("fl_after", 1'b0, 2'd0, 6'h00, bundle(4));
        tick();
        check_out("fl_noacc", 1'b0, 2'd0, 6'h00, bundle(4));

        // Flush with out_ready=1 in ST_ONE: shown bundle is consumed
        out_ready = 1'b1;
        drive(1'b1, 6'h21, bundle(7));
        tick();
        drive(1'b0, 6'h00, '0);
        flush = 1'b1;
        cons_before = n_cons;
        check_out("fl1_shown", 1'b1, 2'd1, 6'h21, bundle(7));
        tick();
        flush = 1'b0;
        check_val("fl1_consumed", {608'd0, n_cons}, {608'd0, cons_before + 1});
        check_out("fl1_empty", 1'b0, 2'd0, 6'h00, bundle(7));

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(1'b1, 6'h21, bundle(8));
        tick();
        drive(1'b1, 6'h21, bundle(9));
        tick();
        drive(1'b0, 6'h00, '0);
        check_out("ar_full", 1'b1, 2'd2, 6'h21, bundle(8));
        rst = 1'b0;
        #1;
        check_out("ar_async", 1'b0, 2'd0, 6'h00, '0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_rdy("ar_release", 1'b1);
        check_out("ar_idle", 1'b0, 2'd0, 6'h00, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for the decode→execute boundary and the later stage boundaries. It carries NUM_LANES data words plus a control vector. Unlike a plain flop bank, it adds a valid/ready handshake, a two-entry skid buffer for full throughput under backpressure, and a synchronous flush that squashes control bits to insert a bubble.

## Interface
Parameters:
- DATA_W, 32, width of one data lane
- NUM_LANES, 20, number of data lanes (pix, cte, mul, i, j, n, wom_addr)
- CTRL_W, 6, width of the control vector (write enables, alu_func)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (clears on assertion, releases on rising clk after deassertion)
- in_valid  in  1  upstream has a valid bundle
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control vector
- in_data  in  NUM_LANES*DATA_W  packed lanes, lane 0 in LSBs
- flush  in  1  synchronous squash of all held entries
- out_valid  out  1  bundle on out_* is valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control vector, forced 0 when out_valid=0
- out_data  out  NUM_LANES*DATA_W  held data lanes
- occ  out  2  entries held: 0, 1 or 2

## Operation
- Two storage entries: main (drives out_*) and skid.
- in_acc = in_valid & in_ready; out_acc = out_valid & out_ready.
- in_ready = (state != ST_FULL) & ~flush. This is combinational from the registered state and flush only, with no path from out_ready.
- States and transitions:
  - ST_EMPTY: in_acc → load main, go to ST_ONE.
  - ST_ONE: in_acc & out_acc → reload main, stay. in_acc only → load skid, go to ST_FULL. out_acc only → ST_EMPTY.
  - ST_FULL: out_acc → main ← skid, go to ST_ONE. in_acc is impossible here.
- flush has highest priority. Next state is ST_EMPTY and both entries' ctrl are cleared to 0. Data registers hold their values. Any input presented in the flush cycle is dropped.
- out_valid = (state != ST_EMPTY). occ encodes the state: 0, 1 or 2.
- Data and ctrl are never modified arithmetically; width is exactly DATA_W per lane.

## Timing
- Reset (rst=0): state ST_EMPTY; all data and ctrl registers 0; out_valid 0; out_ctrl 0; out_data 0; occ 0; in_ready 1. No acceptance while rst=0.
- Latency: 1 cycle. A bundle accepted at edge N appears on out_* after edge N.
- Throughput: one bundle per cycle while out_ready=1.
- Backpressure: the first stalled cycle absorbs one extra bundle into skid. in_ready drops the cycle after the stage reaches ST_FULL.
- Simultaneous in_acc & out_acc in ST_ONE: no bubble, occ stays 1.
- flush together with out_ready=1: the outgoing bundle is still consumed that cycle, then the stage is empty.
- Reset mid-operation: all held bundles are lost immediately and asynchronously. out_valid falls without waiting for clk.
- out_data is stable while out_valid=1 and out_ready=0.

## Structure
- Package pipe_pkg holds `typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} stage_state_t` and the lane-index constants for the decode→execute bundle (LANE_PIX1 … LANE_WOM_ADDR).
- Sub-module flopenr: a parametrised-width, enable-gated flop with asynchronous active-low reset, ports (clk, rst, en, d, q).
  - Two instances each for main/skid data.
  - Two instances each for main/skid ctrl; the ctrl instances take a synchronous clear.
- The FSM lives in pipe_stage_reg itself.

## Test plan
- Reset check: assert rst=0 mid-cycle with two entries held → out_valid=0, occ=0 and out_data=0 immediately; in_ready=1 after release.
- Streaming: out_ready=1; feed ctrl=6'h21 with lane0=32'h0000_0001 … lane19=32'h0000_0014 for 10 consecutive cycles → identical values on out_*, 1 cycle later each, no gaps, occ=1 throughout.
- Backpressure: stream lane0=1,2,3,4 and drop out_ready after the first bundle is shown.
  - Required: occ goes 1→2 and in_ready=0 with 1 shown and 2 held.
  - Raise out_ready: outputs 1,2,3,4 in order with nothing lost or duplicated.
- Flush while full (occ=2, ctrl=6'h3F): pulse flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occ=0, and the input is not accepted.
- Flush with out_ready=1 in ST_ONE: the shown bundle is counted as consumed that cycle and the stage is empty afterwards.
- Parameter sweep: DATA_W=8, NUM_LANES=1, CTRL_W=1 → repeat the streaming and backpressure checks and confirm identical behaviour.
